// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access size encodings,
// FSM state type and the alignment predicate used by the optional
// ALIGN_CHECK_EN build.
package lsu_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'h0;
    localparam logic [1:0] SIZE_HALF = 2'h1;
    localparam logic [1:0] SIZE_WORD = 2'h2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } lsu_state_e;

    // A half needs an even address; a word (size 2 or 3) needs addr[1:0] == 0.
    function automatic logic lsu_misaligned(input logic [1:0] size, input logic [1:0] lo);
        logic mis;
        case (size)
            SIZE_BYTE: mis = 1'b0;
            SIZE_HALF: mis = lo[0];
            default:   mis = (lo != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/lsu_lane.sv
// Combinational lane logic: byte-enable generation and store data
// replication for the request being issued, plus lane selection and
// sign/zero extension for the load being completed.
module lsu_lane
    import lsu_pkg::*;
(
    input  logic [1:0]  st_size,
    input  logic [1:0]  st_lo,
    input  logic [31:0] st_wdata,
    input  logic [1:0]  ld_size,
    input  logic        ld_signed,
    input  logic [1:0]  ld_lo,
    input  logic [31:0] ld_raw,
    output logic [3:0]  be,
    output logic [31:0] wdata_steered,
    output logic [31:0] ld_data
);

    logic [7:0]  ld_byte_s;
    logic [15:0] ld_half_s;

    // Byte enables and replicated store data for the outgoing request.
    always_comb begin
        be            = 4'b1111;
        wdata_steered = st_wdata;
        case (st_size)
            SIZE_BYTE: begin
                be            = 4'b0001 << st_lo;
                wdata_steered = {4{st_wdata[7:0]}};
            end
            SIZE_HALF: begin
                be            = st_lo[1] ? 4'b1100 : 4'b0011;
                wdata_steered = {2{st_wdata[15:0]}};
            end
            default: begin
                be            = 4'b1111;
                wdata_steered = st_wdata;
            end
        endcase
    end

    // Pick the addressed lane of the returned word and extend it.
    always_comb begin
        case (ld_lo)
            2'd0:    ld_byte_s = ld_raw[7:0];
            2'd1:    ld_byte_s = ld_raw[15:8];
            2'd2:    ld_byte_s = ld_raw[23:16];
            default: ld_byte_s = ld_raw[31:24];
        endcase
        if (ld_lo[1]) begin
            ld_half_s = ld_raw[31:16];
        end else begin
            ld_half_s = ld_raw[15:0];
        end
        case (ld_size)
            SIZE_BYTE: ld_data = {{24{ld_signed & ld_byte_s[7]}}, ld_byte_s};
            SIZE_HALF: ld_data = {{16{ld_signed & ld_half_s[15]}}, ld_half_s};
            default:   ld_data = ld_raw;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts a load or store request from the control path,
// performs one word-aligned bus access with byte enables, and returns
// extended load data with a one-cycle done pulse.
// Optional feature macro: ALIGN_CHECK_EN adds a fault output and rejects
// misaligned half/word requests without touching the bus.
module load_store_unit
    import lsu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        MemW,
    input  logic [2:0]  memSelect,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] rdata,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
`ifdef ALIGN_CHECK_EN
    ,
    output logic        fault
`endif
);

    lsu_state_e  state_q, state_d;
    logic        bus_req_q, bus_req_d;
    logic        bus_we_q, bus_we_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [3:0]  bus_be_q, bus_be_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic        done_q, done_d;
    logic [31:0] rdata_q, rdata_d;
    logic [2:0]  sel_q, sel_d;
    logic [1:0]  lo_q, lo_d;
`ifdef ALIGN_CHECK_EN
    logic        fault_q, fault_d;
`endif

    logic        misalign_s;
    logic [3:0]  lane_be_s;
    logic [31:0] lane_wdata_s;
    logic [31:0] lane_ld_s;

`ifdef ALIGN_CHECK_EN
    assign misalign_s = lsu_misaligned(memSelect[1:0], addr[1:0]);
`else
    assign misalign_s = 1'b0;
`endif

    lsu_lane u_lane (
        .st_size       (memSelect[1:0]),
        .st_lo         (addr[1:0]),
        .st_wdata      (wdata),
        .ld_size       (sel_q[1:0]),
        .ld_signed     (sel_q[2]),
        .ld_lo         (lo_q),
        .ld_raw        (bus_rdata),
        .be            (lane_be_s),
        .wdata_steered (lane_wdata_s),
        .ld_data       (lane_ld_s)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a rejected misaligned request jumps straight to RESP.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = misalign_s ? ST_RESP : ST_ACCESS;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (bus_ack) begin
                    state_d = ST_RESP;
                end else begin
                    state_d = ST_ACCESS;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Output/datapath next values: latch the request in IDLE, hold the bus
    // in ACCESS, capture load data on the ack cycle, drop done in RESP.
    always_comb begin
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_be_d    = bus_be_q;
        bus_wdata_d = bus_wdata_q;
        done_d      = 1'b0;
        rdata_d     = rdata_q;
        sel_d       = sel_q;
        lo_d        = lo_q;
`ifdef ALIGN_CHECK_EN
        fault_d     = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    sel_d = memSelect;
                    lo_d  = addr[1:0];
                    if (misalign_s) begin
                        done_d    = 1'b1;
                        bus_req_d = 1'b0;
`ifdef ALIGN_CHECK_EN
                        fault_d   = 1'b1;
`endif
                    end else begin
                        bus_req_d   = 1'b1;
                        bus_we_d    = MemW;
                        bus_addr_d  = {addr[31:2], 2'b00};
                        bus_be_d    = lane_be_s;
                        bus_wdata_d = lane_wdata_s;
                    end
                end else begin
                    bus_req_d = 1'b0;
                end
            end
            ST_ACCESS: begin
                if (bus_ack) begin
                    bus_req_d = 1'b0;
                    done_d    = 1'b1;
                    if (!bus_we_q) begin
                        rdata_d = lane_ld_s;
                    end else begin
                        rdata_d = rdata_q;
                    end
                end else begin
                    bus_req_d = 1'b1;
                end
            end
            ST_RESP: begin
                bus_req_d = 1'b0;
            end
            default: begin
                bus_req_d = 1'b0;
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= 32'h0000_0000;
            bus_be_q    <= 4'b0000;
            bus_wdata_q <= 32'h0000_0000;
            done_q      <= 1'b0;
            rdata_q     <= 32'h0000_0000;
            sel_q       <= 3'b000;
            lo_q        <= 2'b00;
`ifdef ALIGN_CHECK_EN
            fault_q     <= 1'b0;
`endif
        end else begin
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_be_q    <= bus_be_d;
            bus_wdata_q <= bus_wdata_d;
            done_q      <= done_d;
            rdata_q     <= rdata_d;
            sel_q       <= sel_d;
            lo_q        <= lo_d;
`ifdef ALIGN_CHECK_EN
            fault_q     <= fault_d;
`endif
        end
    end

    assign busy      = (state_q != ST_IDLE);
    assign done      = done_q;
    assign rdata     = rdata_q;
    assign bus_req   = bus_req_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_be    = bus_be_q;
    assign bus_wdata = bus_wdata_q;
`ifdef ALIGN_CHECK_EN
    assign fault     = fault_q;
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases followed by
// randomized requests, checked against an arithmetic reference model.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        MemW = 1'b0;
    logic [2:0]  memSelect = 3'b000;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic        busy, done;
    logic [31:0] rdata;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack = 1'b0;
    logic [31:0] bus_rdata = 32'h0;
`ifdef ALIGN_CHECK_EN
    logic        fault;
`endif

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] exp_rdata = 32'h0;

    always #5 clk = ~clk;

    load_store_unit dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .MemW      (MemW),
        .memSelect (memSelect),
        .addr      (addr),
        .wdata     (wdata),
        .busy      (busy),
        .done      (done),
        .rdata     (rdata),
        .bus_req   (bus_req),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_be    (bus_be),
        .bus_wdata (bus_wdata),
        .bus_ack   (bus_ack),
        .bus_rdata (bus_rdata)
`ifdef ALIGN_CHECK_EN
        ,
        .fault     (fault)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Reference model: expected byte enables from size and address.
    function automatic logic [3:0] m_be(input logic [1:0] size, input logic [31:0] a);
        int lo = int'(a[1:0]);
        if (size == 2'd0) return 4'(1 << lo);
        if (size == 2'd1) return 4'(3 << (lo & 2));
        return 4'hF;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [1:0] size, input logic [31:0] wd);
        if (size == 2'd0) return {24'h0, wd[7:0]} * 32'h0101_0101;
        if (size == 2'd1) return {16'h0, wd[15:0]} * 32'h0001_0001;
        return wd;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] sel, input logic [31:0] a, input logic [31:0] raw);
        logic [31:0] v;
        if (sel[1:0] == 2'd0) begin
            v = (raw >> (8 * int'(a[1:0]))) & 32'hFF;
            if (sel[2] && v >= 32'd128) v = v + 32'hFFFF_FF00;
        end else if (sel[1:0] == 2'd1) begin
            v = (raw >> (16 * int'(a[1]))) & 32'hFFFF;
            if (sel[2] && v >= 32'd32768) v = v + 32'hFFFF_0000;
        end else begin
            v = raw;
        end
        return v;
    endfunction

    function automatic bit m_misaligned(input logic [1:0] size, input logic [31:0] a);
`ifdef ALIGN_CHECK_EN
        if (size == 2'd1) return a[0] == 1'b1;
        if (size >= 2'd2) return (a % 4) != 0;
        return 1'b0;
`else
        return 1'b0;
`endif
    endfunction

    // One complete request; poke re-pulses start during ACCESS.
    task automatic run_access(input logic memw, input logic [2:0] sel, input logic [31:0] a,
                              input logic [31:0] wd, input int dly, input logic [31:0] raw,
                              input bit poke);
        logic [3:0]  e_be = m_be(sel[1:0], a);
        logic [31:0] e_wd = m_wdata(sel[1:0], wd);
        logic [31:0] e_ld = m_load(sel, a, raw);
        bit          mis  = m_misaligned(sel[1:0], a);
        @(posedge clk); #1;
        start = 1'b1; MemW = memw; memSelect = sel; addr = a; wdata = wd;
        @(posedge clk); #1;
        start = 1'b0; MemW = ~memw; memSelect = 3'($urandom); addr = $urandom; wdata = $urandom;
        if (mis) begin
            chk("mis_bus_req", 32'(bus_req), 32'd0);
            chk("mis_done", 32'(done), 32'd1);
`ifdef ALIGN_CHECK_EN
            chk("mis_fault", 32'(fault), 32'd1);
`endif
            chk("mis_rdata", rdata, exp_rdata);
            @(posedge clk); #1;
            chk("mis_done_end", 32'(done), 32'd0);
            chk("mis_busy_end", 32'(busy), 32'd0);
            chk("mis_bus_req_end", 32'(bus_req), 32'd0);
`ifdef ALIGN_CHECK_EN
            chk("mis_fault_end", 32'(fault), 32'd0);
`endif
        end else begin
            for (int i = 0; i <= dly; i++) begin
                chk("bus_req", 32'(bus_req), 32'd1);
                chk("bus_we", 32'(bus_we), 32'(memw));
                chk("bus_addr", bus_addr, a & 32'hFFFF_FFFC);
                chk("bus_be", 32'(bus_be), 32'(e_be));
                chk("bus_wdata", bus_wdata, e_wd);
                chk("busy_access", 32'(busy), 32'd1);
                chk("done_access", 32'(done), 32'd0);
                start = (poke && i == 0) ? 1'b1 : 1'b0;
                if (i == dly) begin
                    bus_ack = 1'b1;
                    bus_rdata = raw;
                end
                @(posedge clk); #1;
            end
            bus_ack = 1'b0; start = 1'b0; bus_rdata = $urandom;
            if (!memw) exp_rdata = e_ld;
            chk("done_resp", 32'(done), 32'd1);
            chk("bus_req_resp", 32'(bus_req), 32'd0);
            chk("rdata", rdata, exp_rdata);
`ifdef ALIGN_CHECK_EN
            chk("fault_resp", 32'(fault), 32'd0);
`endif
            @(posedge clk); #1;
            chk("done_after", 32'(done), 32'd0);
            chk("busy_after", 32'(busy), 32'd0);
            chk("bus_req_after", 32'(bus_req), 32'd0);
            chk("rdata_hold", rdata, exp_rdata);
        end
    endtask

    initial begin
        // Reset state.
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_bus_req", 32'(bus_req), 32'd0);
        chk("rst_bus_we", 32'(bus_we), 32'd0);
        chk("rst_bus_be", 32'(bus_be), 32'd0);
        chk("rst_bus_addr", bus_addr, 32'd0);
        chk("rst_bus_wdata", bus_wdata, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
`ifdef ALIGN_CHECK_EN
        chk("rst_fault", 32'(fault), 32'd0);
`endif
        @(posedge clk); #1;
        reset = 1'b0;

        // Store byte at 0x103, ack after 3 cycles.
        run_access(1'b1, 3'b000, 32'h0000_0103, 32'h0000_00A5, 3, 32'h0, 1'b0);
        // Signed and unsigned byte loads.
        run_access(1'b0, 3'b100, 32'h0000_0202, 32'h0, 1, 32'h12F0_0034, 1'b0);
        chk("byte_signed_val", exp_rdata, 32'hFFFF_FFF0);
        run_access(1'b0, 3'b000, 32'h0000_0202, 32'h0, 0, 32'h12F0_0034, 1'b0);
        chk("byte_unsigned_val", exp_rdata, 32'h0000_00F0);
        // Signed half load at 0x06, then word load at 0x04.
        run_access(1'b0, 3'b101, 32'h0000_0006, 32'h0, 2, 32'h8001_0000, 1'b0);
        chk("half_signed_val", exp_rdata, 32'hFFFF_8001);
        run_access(1'b0, 3'b010, 32'h0000_0004, 32'h0, 0, 32'h8001_0000, 1'b0);
        // Store leaves rdata unchanged.
        run_access(1'b1, 3'b010, 32'h0000_0008, 32'hDEAD_BEEF, 1, 32'h1234_5678, 1'b0);

        // Start during ACCESS is ignored.
        run_access(1'b0, 3'b001, 32'h0000_0012, 32'h0, 2, 32'hCAFE_7001, 1'b1);
        // bus_ack in IDLE is ignored.
        @(posedge clk); #1;
        bus_ack = 1'b1;
        @(posedge clk); #1;
        bus_ack = 1'b0;
        chk("idle_ack_done", 32'(done), 32'd0);
        chk("idle_ack_busy", 32'(busy), 32'd0);
        chk("idle_ack_req", 32'(bus_req), 32'd0);
        @(posedge clk); #1;
        chk("idle_ack_done2", 32'(done), 32'd0);

        // Reset in the middle of ACCESS.
        @(posedge clk); #1;
        start = 1'b1; MemW = 1'b0; memSelect = 3'b010; addr = 32'h0000_0040;
        @(posedge clk); #1;
        start = 1'b0;
        chk("mid_req_before", 32'(bus_req), 32'd1);
        reset = 1'b1;
        #1;
        chk("mid_rst_req", 32'(bus_req), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_addr", bus_addr, 32'd0);
        chk("mid_rst_be", 32'(bus_be), 32'd0);
        chk("mid_rst_rdata", rdata, 32'd0);
        exp_rdata = 32'h0;
        @(posedge clk); #1;
        reset = 1'b0;
        bus_ack = 1'b1;
        @(posedge clk); #1;
        bus_ack = 1'b0;
        chk("post_rst_done", 32'(done), 32'd0);
        chk("post_rst_busy", 32'(busy), 32'd0);
        run_access(1'b0, 3'b010, 32'h0000_0040, 32'h0, 1, 32'h0BAD_F00D, 1'b0);

        // Word store at 0x101: rejected with ALIGN_CHECK_EN, else silently aligned.
        run_access(1'b1, 3'b010, 32'h0000_0101, 32'h1122_3344, 0, 32'h0, 1'b0);
`ifndef ALIGN_CHECK_EN
        chk("silent_align_addr", bus_addr, 32'h0000_0100);
        chk("silent_align_be", 32'(bus_be), 32'h0000_000F);
`endif

        // Randomized requests.
        for (int n = 0; n < 40; n++) begin
            run_access(1'($urandom), 3'($urandom), $urandom, $urandom,
                       int'($urandom_range(0, 3)), $urandom, 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have ports: clk  in  1  single clock, all state on rising edge.
REQ-002 SHALL have ports: reset  in  1  asynchronous, active-high; clears all state.
REQ-003 SHALL have ports: start  in  1  request pulse from the control path (load or store).
REQ-004 SHALL have ports: MemW  in  1  1 = store, 0 = load; sampled with start.
REQ-005 SHALL have ports: memSelect  in  3  {loadSigned, size[1:0]}; size 0 = byte, 1 = half, 2 = word, 3 = treated as word.
REQ-006 SHALL have ports: addr  in  32  byte address; wdata  in  32  store data (low bits significant).
REQ-007 SHALL have ports: busy  out  1; done  out  1  one-cycle completion pulse; rdata  out  32  extended load data.
REQ-008 SHALL have ports: bus_req  out  1; bus_we  out  1; bus_addr  out  32 (word-aligned, [1:0] = 0); bus_be  out  4; bus_wdata  out  32.
REQ-009 SHALL have ports: bus_ack  in  1; bus_rdata  in  32.
REQ-010 SHALL have port fault  out  1 only when ALIGN_CHECK_EN is defined.

Function
REQ-011 SHALL implement FSM IDLE -> ACCESS -> RESP -> IDLE.
REQ-012 SHALL in IDLE, on start: latch MemW, memSelect and addr, steer wdata, and enter ACCESS. bus_req is high from the next cycle.
REQ-013 SHALL hold bus_req, bus_we, bus_addr, bus_be and bus_wdata constant in ACCESS until a cycle with bus_ack = 1, then enter RESP.
REQ-014 SHALL pulse done in RESP for exactly one cycle, then return to IDLE. Minimum latency: start at cycle 0, ack at cycle 1, done at cycle 2.
REQ-015 SHALL ignore start while busy (busy = state != IDLE) and ignore bus_ack outside ACCESS.
REQ-016 SHALL generate bus_be as follows: byte = 4'b0001 << addr[1:0]; half = addr[1] ? 4'b1100 : 4'b0011; word = 4'b1111.
REQ-017 SHALL replicate store data: byte = wdata[7:0] x4; half = wdata[15:0] x2; word = wdata.
REQ-018 SHALL, on load, capture bus_rdata on the ack cycle: select the byte lane addr[1:0] or the half lane addr[1], then sign-extend if loadSigned, else zero-extend. Word loads pass through unchanged.
REQ-019 SHALL hold rdata stable from RESP until the next load completes. Stores leave rdata unchanged.
REQ-020 SHALL, without the alignment check, ignore addr[0] for half and addr[1:0] for word (silent alignment).

Reset
REQ-021 SHALL, on reset (including mid-ACCESS), immediately force state IDLE, bus_req 0, bus_we 0, done 0, busy 0, bus_be 0, bus_addr 0, bus_wdata 0, rdata 0 and fault 0. An in-flight access is abandoned with no done pulse.

Configuration
REQ-022 SHALL honour macro ALIGN_CHECK_EN. When defined, a misaligned start (half with addr[0] = 1, or word with addr[1:0] != 0) skips ACCESS and never raises bus_req. It goes directly to RESP with done = 1 and fault = 1 for that one cycle, and rdata is unchanged.
REQ-023 SHALL, without ALIGN_CHECK_EN, have no fault port, and REQ-020 applies.

Structure
REQ-024 SHALL place the size encodings BYTE = 2'h0, HALF = 2'h1 and WORD = 2'h2, and the FSM state enum, in shared package lsu_pkg.
REQ-025 SHALL place lane steering, byte-enable generation and load extension in combinational sub-module lsu_lane, instantiated once.

Verification
REQ-026 Test: store byte, addr 0x103, wdata 0x000000A5, ack after 3 cycles -> bus_addr 0x100, bus_be 4'b1000, bus_wdata 0xA5A5A5A5, bus_we 1, done 1 cycle after ack.
REQ-027 Test: signed byte load, addr 0x202, bus_rdata 0x12F00034 -> rdata 0xFFFFFFF0. The unsigned case -> 0x000000F0.
REQ-028 Test: signed half load, addr 0x06, bus_rdata 0x80010000 -> bus_be 4'b1100, rdata 0xFFFF8001. Word load, addr 0x04 -> rdata 0x80010000.
REQ-029 Test: start pulsed again during ACCESS, and bus_ack pulsed in IDLE -> no second access, no spurious done.
REQ-030 Test: reset asserted mid-ACCESS -> bus_req low in the same cycle (asynchronous), no done. The next start then completes normally.
REQ-031 Test: with ALIGN_CHECK_EN, word store at addr 0x101 -> bus_req never asserted, done = fault = 1 for one cycle. Without the macro -> bus_addr 0x100, bus_be 4'b1111.
